// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state encoding and request fault classification for the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    // First match wins: illegal encoding, then alignment, then address range.
    // BU/HU (funct3[2]) are load-only, so a store with funct3[2] set is illegal.
    function automatic logic [1:0] check_fault(input logic we, input logic [2:0] f3,
                                               input logic [31:0] addr, input logic [32:0] limit);
        return ((f3[1:0] == 2'b11) || (f3[2] && (f3[1] || we))) ? FLT_ILLEGAL
             : ((f3[1:0] == 2'b01 && addr[0]) || (f3[1] && addr[1:0] != 2'b00)) ? FLT_MISALIGN
             : ({1'b0, addr} >= limit) ? FLT_RANGE
             : FLT_OK;
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response handshake plus the memory data port of the load/store unit
//   req_*   : request from MEM stage (valid/ready handshake, we, funct3, byte addr, store data)
//   resp_*  : one-cycle completion pulse with extended load data and fault code
//   mem_*   : word-aligned address, write enable, write data, combinational read data
//   slave   : the load/store unit; master : pipeline plus memory side
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] mem_addr;
    logic        MemWrite;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, MemWrite, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, MemWrite, mem_write_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction for loads and lane merge for sub-word stores
//   load_word  : word read from memory      merge_word : word to merge store data into
//   wdata      : store data (low byte/half) off        : byte offset addr[1:0]
//   funct3     : access size / signedness
//   load_data  : selected lane, sign/zero extended
//   merge_data : merge_word with addressed lane(s) replaced
module lsu_lane_align (
    input  logic [31:0] load_word,
    input  logic [31:0] merge_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask;
    logic [31:0] lanes;

    always_comb begin
        lane_b     = load_word[{off, 3'b000} +: 8];
        lane_h     = off[1] ? load_word[31:16] : load_word[15:0];
        // funct3[2] marks the unsigned variants, so it suppresses sign replication.
        load_data  = funct3[1] ? load_word
                   : funct3[0] ? {{16{~funct3[2] & lane_h[15]}}, lane_h}
                   : {{24{~funct3[2] & lane_b[7]}}, lane_b};
        mask       = funct3[1] ? 32'hFFFF_FFFF
                   : funct3[0] ? 32'h0000_FFFF << {off[1], 4'b0000}
                   : 32'h0000_00FF << {off, 3'b000};
        lanes      = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        merge_data = (merge_word & ~mask) | (lanes & mask);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: requester side of the memory data port with sub-word access, RMW stores and faults
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsu_if.slave carrying req_*, resp_* and mem_* signals
//   MEM_WORDS: words of attached memory; byte addresses at or beyond MEM_WORDS*4 fault
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 8192
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;
    logic [1:0]  req_fault;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    lsu_lane_align u_align (
        .load_word (bus.mem_read_data),
        .merge_word(word_q),
        .wdata     (wdata_q),
        .off       (addr_q[1:0]),
        .funct3    (f3_q),
        .load_data (load_data),
        .merge_data(merge_data)
    );

    assign req_fault          = check_fault(bus.req_we, bus.req_funct3, bus.req_addr, 33'(MEM_WORDS) * 33'd4);
    assign bus.req_ready      = state_q == IDLE;
    assign bus.resp_valid     = state_q == RESP;
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_fault     = fault_q;
    assign bus.mem_addr       = {addr_q[31:2], 2'b00};
    // Gated by rst so an aborted store cannot write during the reset cycle itself.
    assign bus.MemWrite       = ~rst & ((state_q == ACCESS && we_q && f3_q == F3_W) || state_q == MERGE);
    assign bus.mem_write_data = state_q == MERGE ? merge_data : wdata_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                f3_d    = bus.req_funct3;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                state_d = req_fault != FLT_OK ? RESP : ACCESS;
                if (req_fault != FLT_OK) begin
                    fault_d = req_fault;
                    rdata_d = '0;
                end
            end
            ACCESS: if (we_q && f3_q != F3_W) begin
                word_d  = bus.mem_read_data;
                state_d = MERGE;
            end else begin
                state_d = RESP;
                fault_d = FLT_OK;
                rdata_d = we_q ? '0 : load_data;
            end
            MERGE: begin
                state_d = RESP;
                fault_d = FLT_OK;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            fault_q <= FLT_OK;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end
endmodule
